// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction constants and the fetch-stage
// state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  OP_J      = 6'b000010;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Prioritised next-PC mux: jump beats branch, and either one beats sequential PC+4.
// Purely combinational, so the target selection can be exercised on its own.
module next_pc_sel (
  input  logic [31:0] pc_i,
  input  logic [31:0] if_id_pc_plus4_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] next_pc_o,
  output logic        redirect_o
);

  logic [31:0] jump_pc;
  logic [31:0] branch_pc;

  // The jump keeps the region bits of the instruction's PC+4; branches drop misaligned low bits.
  assign jump_pc   = (if_id_pc_plus4_i & 32'hF000_0000) | {4'b0000, jump_index_i, 2'b00};
  assign branch_pc = branch_target_i & 32'hFFFF_FFFC;

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    next_pc_o  = pc_i + 32'd4;
    redirect_o = jump_i | branch_taken_i;
    if (jump_i) begin
      next_pc_o = jump_pc;
    end else if (branch_taken_i) begin
      next_pc_o = branch_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ready handshake, and fills the IF/ID register that feeds the splitter.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] next_pc;
  logic        redirect;
  logic        handshake;

  next_pc_sel u_next_pc_sel (
    .pc_i             (pc_q),
    .if_id_pc_plus4_i (pc4_q),
    .jump_i           (jump),
    .jump_index_i     (jump_index),
    .branch_taken_i   (branch_taken),
    .branch_target_i  (branch_target),
    .next_pc_o        (next_pc),
    .redirect_o       (redirect)
  );

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign handshake = imem_req & imem_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;

    case (state_q)
      BOOT:        state_d = FETCH;
      FETCH, HOLD: state_d = stall ? HOLD : FETCH;
      default:     state_d = BOOT;
    endcase

    // Redirect and flush both squash IF/ID and any response landing this cycle.
    if (redirect) begin
      pc_d    = next_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (handshake && !stall) begin
      pc_d    = next_pc;
      instr_d = imem_rdata;
      pc4_d   = next_pc;
      valid_d = 1'b1;
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction splitter.
- Owns the PC and issues requests to instruction memory using a req/ready handshake.
- Applies branch and jump redirects.
- Drives the IF/ID pipeline register whose instruction word feeds the splitter.
- Supports stall, flush and a retired-fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0)
CNT_W, 32, width of the fetch counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  instruction memory word address (equals PC)
imem_req  output  1  fetch request
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory accepts the request and returns data in the same cycle
stall  input  1  hazard stall from decode; hold PC and IF/ID
flush  input  1  kill the IF/ID contents
branch_taken  input  1  redirect to branch_target
branch_target  input  32  branch destination
jump  input  1  redirect to the jump target
jump_index  input  26  instr[25:0] of the J-type instruction
if_id_instr  output  32  registered instruction to the splitter
if_id_pc_plus4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  IF/ID slot holds a real instruction
fetch_count  output  CNT_W  number of instructions written into IF/ID

Behaviour:
Clocking and reset
- Single clock domain. Reset is asynchronous and active-low: rst_n low clears state immediately, and release is sampled on clk.
- Reset values:
  - PC = RESET_PC
  - state = BOOT
  - if_id_instr = 32'h0000_0000 (NOP)
  - if_id_pc_plus4 = 0, if_id_valid = 0, fetch_count = 0
  - imem_req = 0
- Reset asserted mid-request abandons the request. No IF/ID write occurs.

State machine (states BOOT, FETCH, HOLD)
- BOOT: imem_req=0 for exactly one cycle after reset release, then go to FETCH.
- FETCH: imem_req=1 and imem_addr=PC.
  - If the handshake completes (req & ready) with no stall, flush or redirect:
    - if_id_instr <= imem_rdata
    - if_id_pc_plus4 <= PC+4
    - if_id_valid <= 1
    - PC <= PC+4
    - fetch_count += 1
  - If ready=0, hold PC and the request. Addresses are stable while the request is outstanding.
  - If stall=1, go to HOLD.
- HOLD: imem_req=0; PC and IF/ID hold. Return to FETCH on the first cycle stall=0.

Event priority (highest first)
1. Reset.
2. Redirect. jump takes priority over branch_taken.
   - Jump target = {PC_id[31:28], jump_index, 2'b00}, where PC_id is if_id_pc_plus4.
   - Branch target = {branch_target[31:2], 2'b00}. Misaligned low bits are forced to 0.
   - On a redirect: PC <= target, if_id_valid <= 0, if_id_instr <= NOP, and any same-cycle memory response is discarded with no count.
   - Next state is FETCH, even if stall=1.
3. flush (without redirect): if_id_valid <= 0 and if_id_instr <= NOP. A same-cycle response is dropped, PC does not advance, and the same address is refetched.
4. stall: PC, IF/ID and fetch_count hold, and any same-cycle response is ignored.
5. Normal fetch, as described under FETCH.

Arithmetic and widths
- PC+4 wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- fetch_count wraps at 2^CNT_W.

Timing
- Latency: an instruction appears on the if_id_* outputs one cycle after its handshake cycle.
- Throughput is one instruction per cycle when imem_ready=1 continuously.
- All outputs are registered except imem_addr and imem_req, which are decoded from registered state and PC.

Decomposition:
Shared package mips_pkg:
- NOP_INSTR = 32'h0000_0000
- OP_J = 6'b000010
- Fetch state encoding: BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2

Sub-module next_pc_sel:
- Purely combinational.
- Inputs: PC, if_id_pc_plus4, jump, jump_index, branch_taken, branch_target.
- Outputs: next_pc and a redirect flag.
- Lets the prioritised target mux be unit-tested alone.

Test Plan:
1. Reset release with imem_ready=1, imem_rdata incrementing -> imem_req=0 for 1 cycle, then addresses 0, 4, 8; if_id_instr follows 1 cycle later and fetch_count = 3 after 3 handshakes.
2. imem_ready held low for 3 cycles at PC=0x10 -> imem_addr stays 0x10 and req stays 1; IF/ID is written once when ready rises and fetch_count increments by 1.
3. stall high for 2 cycles at PC=0x20 -> imem_req=0 and IF/ID unchanged; the fetch of 0x20 resumes the cycle after stall falls.
4. jump=1 with jump_index=26'h0000040 and if_id_pc_plus4=0x10000008, asserted together with branch_taken -> next imem_addr=0x10000100, if_id_valid=0 and if_id_instr=0.
5. branch_taken with branch_target=0x00000043 during a completing handshake -> response discarded, no count, next imem_addr=0x40.
6. RESET_PC=32'hFFFF_FFFC -> second fetch address is 0x00000000 and if_id_pc_plus4=0; rst_n pulsed low mid-FETCH -> all outputs return to reset values immediately.
